// File: rtl/pu_pkg.sv
// pu_pkg: shared types and constants for the pu_mac_array datapath.
//   acc_state_t  - accumulator FSM states (IDLE / ACCUM)
//   PU_DATA_W    - default operand / result width
//   PU_LANES     - default operand pairs per beat
//   tree_depth() - number of adder levels needed to reduce 'lanes' values
package pu_pkg;

    localparam int PU_DATA_W = 32;
    localparam int PU_LANES  = 4;

    typedef enum logic {
        ACC_IDLE  = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_t;

    function automatic int tree_depth(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/pu_adder_tree.sv
// pu_adder_tree: combinational pairwise reduction of LANES signed values.
// Ports:
//   operands - LANES packed signed inputs, IN_W bits each (lane 0 in the LSBs)
//   sum      - signed sum, IN_W + clog2(LANES) bits (cannot overflow)
// LANES must be a power of two, at least 2.
module pu_adder_tree
    import pu_pkg::*;
#(
    parameter int LANES = PU_LANES,
    parameter int IN_W  = 2 * PU_DATA_W
) (
    input  logic [LANES*IN_W-1:0]                     operands,
    output logic signed [IN_W+tree_depth(LANES)-1:0]  sum
);

    localparam int DEPTH = tree_depth(LANES);
    localparam int OUT_W = IN_W + DEPTH;

    genvar gl;
    genvar gi;

    // Level 0 holds the sign-extended leaves; level gl holds LANES>>gl
    // partial sums, each the sum of two neighbours from level gl-1.
    generate
        for (gl = 0; gl <= DEPTH; gl++) begin : g_lvl
            logic signed [OUT_W-1:0] node [LANES >> gl];
            for (gi = 0; gi < (LANES >> gl); gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    assign node[gi] = OUT_W'($signed(operands[gi*IN_W +: IN_W]));
                end else begin : g_add
                    assign node[gi] = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
                end
            end
        end
    endgenerate

    assign sum = g_lvl[DEPTH].node[0];

endmodule

// File: rtl/pu_mac_array.sv
// pu_mac_array: LANES-wide signed dot-product / neuron datapath.
// Three pipeline stages: multiply -> adder-tree reduce -> accumulate + ReLU.
// Ports:
//   clock, reset_n       - rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    - input beat handshake; in_last closes a vector
//   x, w                 - LANES signed operands each (lane 0 in the LSBs)
//   out_valid/out_ready  - result handshake
//   out_data, out_zero   - ReLU result and its zero flag
// Build option: define PU_SAT_EN to saturate the result at the largest
// positive DATA_W value; otherwise the result is truncated to DATA_W bits.
module pu_mac_array
    import pu_pkg::*;
#(
    parameter int DATA_W = PU_DATA_W,
    parameter int LANES  = PU_LANES,
    parameter int ACC_W  = 2 * DATA_W + 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] x,
    input  logic [LANES*DATA_W-1:0] w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_zero
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int TREE_W = PROD_W + tree_depth(LANES);

    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

    // Whole pipeline moves together; it freezes only while a result waits.
    logic adv;

    logic [LANES*PROD_W-1:0] prod_next;
    logic [LANES*PROD_W-1:0] prod_reg;
    logic                    s1_valid_reg;
    logic                    s1_last_reg;

    logic signed [TREE_W-1:0] tree_sum;
    logic signed [ACC_W-1:0]  sum_next;
    logic signed [ACC_W-1:0]  sum_reg;
    logic                     s2_valid_reg;
    logic                     s2_last_reg;

    acc_state_t               state_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  total_next;
    logic [DATA_W-1:0]        conv_next;

    logic                     out_valid_reg;
    logic [DATA_W-1:0]        out_data_reg;
    logic                     out_zero_reg;

    assign adv      = !out_valid_reg || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: per-lane multiply ----------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_mul
            logic signed [PROD_W-1:0] x_ext;
            logic signed [PROD_W-1:0] w_ext;
            assign x_ext = PROD_W'($signed(x[gi*DATA_W +: DATA_W]));
            assign w_ext = PROD_W'($signed(w[gi*DATA_W +: DATA_W]));
            // Full product of two DATA_W values always fits in PROD_W bits.
            assign prod_next[gi*PROD_W +: PROD_W] = x_ext * w_ext;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            prod_reg     <= '0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            // A last flag without a valid beat carries no meaning.
            s1_last_reg  <= in_valid && in_last;
            prod_reg     <= prod_next;
        end
    end

    // ---------------- stage 2: reduce ----------------
    pu_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_tree (
        .operands (prod_reg),
        .sum      (tree_sum)
    );

    // tree_sum is signed, so the size cast sign-extends into the accumulator.
    assign sum_next = ACC_W'(tree_sum);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            sum_reg      <= '0;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            sum_reg      <= sum_next;
        end
    end

    // ---------------- stage 3: accumulate, ReLU, convert ----------------
    // In IDLE the accumulator is zero by construction, but selecting zero
    // explicitly keeps the first beat of a vector independent of acc_reg.
    assign total_next = ((state_reg == ACC_IDLE) ? ACC_ZERO : acc_reg) + sum_reg;

`ifdef PU_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    always_comb begin
        conv_next = '0;
        if (total_next > ACC_ZERO) begin
            if (total_next > SAT_MAX) begin
                conv_next = SAT_MAX[DATA_W-1:0];
            end else begin
                conv_next = total_next[DATA_W-1:0];
            end
        end
    end
`else
    // Positive totals are truncated to DATA_W bits and may wrap.
    always_comb begin
        conv_next = '0;
        if (total_next > ACC_ZERO) begin
            conv_next = total_next[DATA_W-1:0];
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= ACC_IDLE;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_zero_reg  <= 1'b1;
        end else if (adv) begin
            // Default: the previous result (if any) was consumed this edge.
            out_valid_reg <= 1'b0;
            if (s2_valid_reg) begin
                if (s2_last_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= conv_next;
                    out_zero_reg  <= (conv_next == '0);
                end
                case (state_reg)
                    ACC_IDLE: begin
                        if (!s2_last_reg) begin
                            acc_reg   <= total_next;
                            state_reg <= ACC_ACCUM;
                        end
                    end
                    ACC_ACCUM: begin
                        if (s2_last_reg) begin
                            acc_reg   <= '0;
                            state_reg <= ACC_IDLE;
                        end else begin
                            acc_reg   <= total_next;
                        end
                    end
                    default: begin
                        acc_reg   <= '0;
                        state_reg <= ACC_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_zero  = out_zero_reg;

endmodule

// File: tb/tb_pu_mac_array.sv
// tb_pu_mac_array: directed scenarios followed by a randomized run, all
// checked against a dot-product reference model (queue of expected results).
module tb_pu_mac_array;

    localparam int DW    = 32;
    localparam int LANES = 4;
    localparam int VW    = LANES * DW;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [VW-1:0] x;
    logic [VW-1:0] w;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_zero;

    pu_mac_array #(
        .DATA_W (DW),
        .LANES  (LANES),
        .ACC_W  (2*DW+8)
    ) dut (
        .clock     (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .x         (x),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic signed [127:0] model_tot = '0;
    logic [31:0]         exp_q[$];

    // Values sampled just before each active edge
    logic          obs_valid;
    logic          obs_ready;
    logic          obs_zero;
    logic [DW-1:0] obs_data;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_zero;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    // Result for a vector total: wrap to 72 bits, ReLU, then saturate or truncate.
    function automatic logic [31:0] conv_model(input logic signed [127:0] t);
        logic signed [71:0] tw;
        tw = t[71:0];
        if (tw <= 0) return 32'h0;
`ifdef PU_SAT_EN
        if (tw > 72'sh7FFF_FFFF) return 32'h7FFF_FFFF;
`endif
        return tw[31:0];
    endfunction

    task automatic model_beat(input logic [VW-1:0] xv, input logic [VW-1:0] wv, input logic l);
        for (int i = 0; i < LANES; i++) begin
            logic signed [31:0] xi;
            logic signed [31:0] wi;
            xi = xv[i*32 +: 32];
            wi = wv[i*32 +: 32];
            model_tot = model_tot + 128'(longint'(xi) * longint'(wi));
        end
        if (l) begin
            exp_q.push_back(conv_model(model_tot));
            model_tot = '0;
        end
    endtask

    // One clock cycle: drive, sample before the edge, score, advance.
    task automatic step(input logic rn, input logic v, input logic l,
                        input logic [VW-1:0] xv, input logic [VW-1:0] wv, input logic ordy);
        logic [31:0] e;
        reset_n   = rn;
        in_valid  = v;
        in_last   = l;
        x         = xv;
        w         = wv;
        out_ready = ordy;
        #1;
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_data  = out_data;
        obs_zero  = out_zero;
        if (rn) begin
            check("in_ready", obs_ready, !obs_valid || ordy);
            if (hold_prev) begin
                check("hold_valid", obs_valid, 1'b1);
                check("hold_data", obs_data, held_data);
                check("hold_zero", obs_zero, held_zero);
            end
            if (obs_valid && ordy) begin
                check("sb_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", obs_data, e);
                    check("sb_zero", obs_zero, e == 32'h0);
                    $display("result data=0x%08h zero=%0b expected=0x%08h", obs_data, obs_zero, e);
                end
            end
            if (v && obs_ready) model_beat(xv, wv, l);
            hold_prev = obs_valid && !ordy;
            held_data = obs_data;
            held_zero = obs_zero;
        end
        @(posedge clk);
        #2;
        if (!rn) begin
            exp_q.delete();
            model_tot = '0;
            hold_prev = 1'b0;
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b1, 1'b0, 1'b0, '0, '0, ordy);
    endtask

    // Step idle cycles with out_ready high until a result appears (bounded).
    task automatic wait_result(input string tag, input logic [31:0] exp_data, input int exp_edges);
        int n;
        for (n = 1; n <= 10; n++) begin
            idle(1'b1);
            if (obs_valid) break;
        end
        check({tag, "_latency"}, n, exp_edges);
        check({tag, "_data"}, obs_data, exp_data);
        check({tag, "_zero"}, obs_zero, exp_data == 32'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_zero"}, out_zero, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [VW-1:0] x1234;
        logic [VW-1:0] w5678;
        logic [VW-1:0] ones;
        logic [31:0]   ovf_exp;
        int            held;
        x1234 = pack4(1, 2, 3, 4);
        w5678 = pack4(5, 6, 7, 8);
        ones  = pack4(1, 1, 1, 1);

        // Reset
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_reset_state("reset");

        // Single beat: 1*5+2*6+3*7+4*8 = 70, valid 3 edges after acceptance
        step(1'b1, 1'b1, 1'b1, x1234, w5678, 1'b1);
        wait_result("single", 32'd70, 3);

        // Negative total clamps to zero
        step(1'b1, 1'b1, 1'b1, pack4(-1, -2, 0, 0), pack4(3, 4, 0, 0), 1'b1);
        wait_result("clamp", 32'd0, 3);

        // Two beats, one result: 4 + 24 = 28
        step(1'b1, 1'b1, 1'b0, ones, ones, 1'b1);
        step(1'b1, 1'b1, 1'b1, pack4(2, 2, 2, 2), pack4(3, 3, 3, 3), 1'b1);
        wait_result("multi", 32'd28, 3);
        idle(1'b1);
        idle(1'b1);
        check("multi_single_result", out_valid, 1'b0);

        // in_last without in_valid is ignored: this vector ends on the next beat
        step(1'b1, 1'b1, 1'b0, ones, ones, 1'b1);
        step(1'b1, 1'b0, 1'b1, x1234, w5678, 1'b1);
        step(1'b1, 1'b1, 1'b1, ones, ones, 1'b1);
        wait_result("ghost_last", 32'd8, 3);

        // Backpressure: 70 then 4 with out_ready low
        step(1'b1, 1'b1, 1'b1, x1234, w5678, 1'b0);
        step(1'b1, 1'b1, 1'b1, ones, ones, 1'b0);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            if (obs_valid) begin
                held++;
                check("bp_hold_data", obs_data, 32'd70);
                check("bp_hold_in_ready", obs_ready, 1'b0);
            end
        end
        check("bp_hold_cycles", held, 4);
        wait_result("bp_first", 32'd70, 1);
        wait_result("bp_second", 32'd4, 1);

        // Overflow: 4 * (2^30 * 4) = 2^34
`ifdef PU_SAT_EN
        ovf_exp = 32'h7FFF_FFFF;
`else
        ovf_exp = 32'h0;
`endif
        step(1'b1, 1'b1, 1'b1, pack4(1 << 30, 1 << 30, 1 << 30, 1 << 30), pack4(4, 4, 4, 4), 1'b1);
        wait_result("overflow", ovf_exp, 3);

        // Reset mid-vector discards the partial sum
        step(1'b1, 1'b1, 1'b0, pack4(9, 9, 9, 9), pack4(9, 9, 9, 9), 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        check_reset_state("midrst");
        step(1'b1, 1'b1, 1'b1, x1234, w5678, 1'b1);
        wait_result("after_rst", 32'd70, 3);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [VW-1:0] xv;
            logic [VW-1:0] wv;
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    xv[i*32 +: 32] = $urandom();
                    wv[i*32 +: 32] = $urandom();
                end else begin
                    xv[i*32 +: 32] = 32'($urandom_range(0, 16)) - 32'd8;
                    wv[i*32 +: 32] = 32'($urandom_range(0, 16)) - 32'd8;
                end
            end
            step(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, xv, wv,
                 $urandom_range(0, 9) < 7);
        end
        for (int c = 0; c < 30; c++) idle(1'b1);
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pu_mac_array.md
# pu_mac_array

Parametrised successor to the four-input process unit. The block accepts vectors of LANES signed operand pairs over a valid/ready stream and multiplies each pair in a registered stage. It reduces the products through an adder tree and accumulates the sums over one or more beats, up to the beat marked last. The accumulated total passes through a ReLU and is presented on a valid/ready output stream with a zero flag. It is the dot-product/neuron datapath element instantiated by the layer controller.

## Interface
- DATA_W, 32: width of each operand and of out_data.
- LANES, 4: operand pairs per beat; power of two, at least 2.
- ACC_W, 2*DATA_W+8: accumulator width, signed.
- clock: input, 1 bit. Rising-edge clock.
- reset_n: input, 1 bit. Synchronous, active-low reset.
- in_valid: input, 1 bit. Input beat valid.
- in_ready: output, 1 bit. Block can accept a beat.
- in_last: input, 1 bit. This beat closes the current vector.
- x: input, LANES×DATA_W bits. Signed activations.
- w: input, LANES×DATA_W bits. Signed weights.
- out_valid: output, 1 bit. Result valid.
- out_ready: input, 1 bit. Consumer accepts the result.
- out_data: output, DATA_W bits. ReLU result.
- out_zero: output, 1 bit. 1 when out_data == 0.

## Operation
- Global advance signal: adv = !out_valid || out_ready. When adv = 0, every register holds its value.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- Stage 1 (multiply):
  - Registers LANES full-width products p[i] = x[i]*w[i], each signed and 2*DATA_W bits.
  - Also registers the beat's valid bit and last bit.
- Stage 2 (reduce):
  - pu_adder_tree sums the stage-1 products, sign-extended to ACC_W.
  - The sum is registered with its valid bit and last bit.
- Stage 3 (accumulate). Accumulator FSM with two states:
  - IDLE: acc == 0, no partial vector.
    - Stage-2 valid and not last: acc <= sum, go to ACCUM.
    - Stage-2 valid and last: load the output, stay in IDLE.
  - ACCUM: a partial vector is held.
    - Stage-2 valid and not last: acc <= acc + sum.
    - Stage-2 valid and last: load the output with acc + sum, acc <= 0, go to IDLE.
- Output load:
  - total = (IDLE ? 0 : acc) + sum, computed in ACC_W bits; overflow of ACC_W wraps.
  - r = total > 0 ? total : 0.
  - out_data <= conv(r), where conv is defined under Configuration.
  - out_zero <= (conv(r) == 0).
  - out_valid <= 1.
- If no output load occurs on an adv cycle, out_valid <= 0. Handshakes therefore complete back-to-back without bubbles.
- A vector of any beat count (1..∞) produces exactly one result.

## Timing
- Reset (reset_n low at a rising edge) sets:
  - all stage valid bits to 0, FSM to IDLE, acc to 0;
  - out_valid = 0, out_data = 0, out_zero = 1;
  - in_ready = 1 from the first cycle after reset.
- Reset mid-vector discards the partial accumulation and all in-flight beats.
- Latency: a last beat accepted at edge T produces out_valid = 1 in the cycle after edge T+2 (3 edges). This holds with no stalls; each stall cycle adds one.
- Throughput: one beat per cycle while out_ready = 1 or out_valid = 0.
- While out_valid && !out_ready:
  - out_data and out_zero are stable;
  - in_ready = 0;
  - the pipeline is frozen.
- Simultaneous out_ready and a new result on the same edge: the output register reloads and out_valid stays 1.
- in_last on a beat with in_valid = 0 is ignored.

## Configuration
- Macro: PU_SAT_EN.
  - Defined: conv(r) = min(r, 2^(DATA_W-1)-1), i.e. the result saturates to the maximum positive value.
  - Undefined: conv(r) = r[DATA_W-1:0], i.e. the result is truncated and may wrap. out_zero follows the truncated value.

## Structure
- Package pu_pkg:
  - typedef acc_state_t for the IDLE/ACCUM enumeration;
  - default constants PU_DATA_W, PU_LANES;
  - function clog2-based tree depth helper.
- Sub-module pu_adder_tree:
  - parameters LANES and IN_W, output width IN_W+clog2(LANES);
  - combinational pairwise reduction;
  - instantiated once, between stage 1 and stage 2.

## Test plan
All scenarios use DATA_W=32 and LANES=4.
- Single beat: x={1,2,3,4}, w={5,6,7,8}, last=1 → out_valid on the 3rd cycle, out_data=70, out_zero=0.
- Negative clamp: x={-1,-2,0,0}, w={3,4,0,0}, last=1 → out_data=0, out_zero=1.
- Multi-beat: beat1 x={1,1,1,1}, w={1,1,1,1}, last=0; then beat2 x={2,2,2,2}, w={3,3,3,3}, last=1 → exactly one result, out_data=28.
- Backpressure: two back-to-back single-beat vectors (70, then 4 from all-ones), with out_ready=0 for 5 cycles:
  - while held: out_data stays 70, in_ready=0;
  - after release: 70 then 4, no loss or duplicates.
- Overflow: x all 2^30, w all 4 (total 2^34):
  - with PU_SAT_EN: out_data=0x7FFFFFFF, out_zero=0;
  - without: out_data=0, out_zero=1.
- Reset mid-vector: beat x={9,9,9,9}, w={9,9,9,9}, last=0, then reset_n low for 1 cycle, then the single-beat scenario → out_data=70; out_valid=0, out_zero=1 during and right after reset.
